// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control sequencer: steps each instruction through fetch/decode/execute/memory/writeback
// and drives datapath controls, with a wait-state watchdog on memory handshakes.
//
// state  | meaning
// FETCH  | read instruction at PC, load IR and PC+4 on mem_ready
// DECODE | compute branch target into ALUOut, dispatch on opcode
// MEMADR | compute lw/sw effective address
// MEMRD  | data read at ALUOut
// MEMWB  | write loaded data to rt
// MEMWR  | data write at ALUOut
// EXEC   | R-type ALU operation
// ALUWB  | write ALU result to rd
// BRANCH | beq compare, load PC from ALUOut when equal
// ADDIEX | addi ALU operation
// ADDIWB | write addi result to rt
// JUMP   | load PC with jump target
// TRAP   | illegal opcode or memory timeout, held until reset
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       illegal,
  output logic       timeout
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

  state_t     cur_state;
  state_t     next_state;
  logic [7:0] wait_cnt;
  logic       mem_state;
  logic       mem_wait;
  logic       wd_expire;
  logic       set_illegal;
  logic       set_timeout;

  assign state     = cur_state;
  assign mem_state = (cur_state == FETCH) || (cur_state == MEMRD) || (cur_state == MEMWR);
  assign mem_wait  = mem_state && !mem_ready;
  assign wd_expire = mem_wait && (wait_cnt == WAIT_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= FETCH;
    end else begin
      cur_state <= next_state;
    end
  end

  // Counts only consecutive stalled cycles within one memory state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 8'd0;
    end else if (mem_wait && (next_state == cur_state)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (set_illegal) illegal <= 1'b1;
      if (set_timeout) timeout <= 1'b1;
    end
  end

  always_comb begin
    next_state  = cur_state;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    pc_en       = 1'b0;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    pc_src      = 2'b00;

    unique case (cur_state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          // Load enables stay low while reset is held even though the state shows FETCH.
          ir_write   = reset;
          pc_en      = reset;
          next_state = DECODE;
        end else if (wd_expire) begin
          next_state  = TRAP;
          set_timeout = 1'b1;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:     next_state = EXEC;
          OP_LW, OP_SW: next_state = MEMADR;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default: begin
            next_state  = TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          next_state = MEMWB;
        end else if (wd_expire) begin
          next_state  = TRAP;
          set_timeout = 1'b1;
        end
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        next_state = FETCH;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          next_state = FETCH;
        end else if (wd_expire) begin
          next_state  = TRAP;
          set_timeout = 1'b1;
        end
      end
      EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        next_state = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_en      = zero;
        next_state = FETCH;
      end
      ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
        next_state = FETCH;
      end
      JUMP: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        next_state = FETCH;
      end
      TRAP: begin
        next_state = TRAP;
      end
      default: begin
        next_state = TRAP;
      end
    endcase
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle MIPS control sequencer. It drives the load enables of the 32-bit datapath registers (PC, IR) and the mux, ALU and memory controls, stepping each instruction through fetch, decode, execute, memory and writeback states. Memory accesses use a ready handshake, protected by a wait-state watchdog. It sits beside the datapath, taking opcode and ALU zero from it and returning per-cycle control.

## Interface
- MEM_TIMEOUT, 15: maximum consecutive cycles spent waiting for mem_ready in one memory state before trapping (1..255).
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; 0 forces FETCH and clears all status.
- opcode  input  6  IR[31:26] from the datapath.
- zero  input  1  ALU zero flag; valid in BRANCH.
- mem_ready  input  1  memory completes the current read or write this cycle.
- pc_en  output  1  PC register load enable.
- ir_write  output  1  IR load enable.
- mem_read, mem_write  output  1 each  memory strobes.
- iord  output  1  0 selects the PC address, 1 selects the ALUOut address.
- reg_write, reg_dst, mem_to_reg  output  1 each  register-file controls.
- alu_src_a  output  1  0 selects PC, 1 selects regA.
- alu_src_b  output  2  00 regB, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- alu_op  output  2  00 add, 01 sub, 10 funct-decoded.
- pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target.
- state  output  4  current state code, for debug.
- illegal  output  1  sticky: unsupported opcode trapped.
- timeout  output  1  sticky: memory watchdog trapped.

## Operation
- States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, TRAP 12.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write=1 and pc_en=1 only in a cycle where mem_ready=1.
  - Transition: DECODE on mem_ready, otherwise stay.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode: 000000 to EXEC; 100011 (lw) or 101011 (sw) to MEMADR; 000100 (beq) to BRANCH; 001000 (addi) to ADDIEX; 000010 (j) to JUMP; any other opcode to TRAP with illegal set.
- MEMADR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Transition: MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, iord=1. Transition: MEMWB on mem_ready, otherwise stay.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Transition: FETCH.
- MEMWR: mem_write=1, iord=1. Transition: FETCH on mem_ready, otherwise stay.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Transition: ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Transition: FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - pc_en equals zero.
  - Transition: FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Transition: ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0. Transition: FETCH.
- JUMP: pc_src=10, pc_en=1. Transition: FETCH.
- TRAP: all controls 0; stays in TRAP until reset is asserted.
- Watchdog:
  - An 8-bit wait counter increments each cycle in FETCH, MEMRD or MEMWR while mem_ready=0.
  - The counter clears on every state change and whenever mem_ready=1.
  - If the counter equals MEM_TIMEOUT while mem_ready=0, the next state is TRAP and timeout sets.
  - mem_ready=1 in that same cycle wins: the normal transition is taken.
- illegal and timeout are never both set.

## Timing
- Reset values while reset=0: state=FETCH (0), wait counter=0, illegal=0, timeout=0.
  - Outputs then show the FETCH decode: mem_read=1, alu_src_b=01, everything else 0.
  - pc_en and ir_write stay 0 while reset=0, regardless of mem_ready.
- Reset assertion mid-instruction takes effect immediately (asynchronous).
  - Deassertion is sampled at the next rising edge; the first fetch starts then.
- The state register updates on the rising clock edge.
- Controls are combinational from the state register, plus mem_ready (FETCH) and zero (BRANCH).
- Cycle counts with mem_ready held at 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
  - Each cycle of mem_ready=0 in a memory state adds one cycle.
- Watchdog trap: mem_ready stuck at 0 in a memory state gives TRAP on edge MEM_TIMEOUT+1 after entering that state.

## Test plan
- Reset: hold reset=0 for 3 cycles with mem_ready=1 -> state=0, pc_en=0, ir_write=0, illegal=0, timeout=0; first edge after release moves to DECODE.
- R-type: opcode=000000, mem_ready=1 -> states 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; pc_en=1 only in the FETCH cycle.
- lw with waits: opcode=100011, mem_ready=0 for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0 (8 cycles); mem_to_reg=1 in state 4.
- beq: zero=1 -> pc_en=1 with pc_src=01 in state 8; zero=0 -> pc_en=0 in state 8; both return to FETCH.
- Illegal opcode 111111 -> TRAP (12) after DECODE, illegal=1, all strobes 0 for 10+ cycles; reset=0 -> state=0, illegal=0.
- Timeout with MEM_TIMEOUT=15: sw with mem_ready=0 -> TRAP on edge 16 after entering MEMWR, timeout=1. Repeat with mem_ready=1 on the 15th wait cycle -> FETCH, no trap. Assert reset mid-wait -> immediate FETCH, counter 0.
